// File: rtl/hba_pkg.sv
// +----------------------------------------------------------------------+
// | hba_pkg : shared HBA bus widths and the bus master state encoding    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package hba_pkg;

  localparam int HBA_DBUS_WIDTH        = 8;
  localparam int HBA_PERIPH_ADDR_WIDTH = 4;
  localparam int HBA_REG_ADDR_WIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } hba_master_state_e;

endpackage : hba_pkg

`default_nettype wire

// File: rtl/hba_bus_master.sv
// +----------------------------------------------------------------------+
// | hba_bus_master : executes single requests as HBA bus cycles with an  |
// | ack timeout and a one-entry response buffer.            Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module hba_bus_master
  import hba_pkg::*;
#(
  parameter int DBUS_WIDTH        = HBA_DBUS_WIDTH,
  parameter int PERIPH_ADDR_WIDTH = HBA_PERIPH_ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH    = HBA_REG_ADDR_WIDTH,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rnw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DBUS_WIDTH-1:0] req_wdata,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DBUS_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,

  output logic                  hba_select,
  output logic                  hba_rnw,
  output logic [ADDR_WIDTH-1:0] hba_abus,
  output logic [DBUS_WIDTH-1:0] hba_dbus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  input  logic                  hba_xferack_slave
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  hba_master_state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  rnw_q,   rnw_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DBUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [DBUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q,   err_d;

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Bus registers are only non-zero during XFER, so the OR-combined bus stays clean.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = XFER;
          cnt_d   = '0;
          rnw_d   = req_rnw;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end

      XFER: begin
        if (hba_xferack_slave || (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          rnw_d   = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          // Ack takes priority over a timeout expiring on the same cycle.
          if (hba_xferack_slave) begin
            rdata_d = rnw_q ? hba_dbus_slave : '0;
            err_d   = 1'b0;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign hba_select = (state_q == XFER);
  assign rsp_valid  = (state_q == RESP);

  assign hba_rnw   = rnw_q;
  assign hba_abus  = addr_q;
  assign hba_dbus  = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule : hba_bus_master

`default_nettype wire

// File: tb/tb_hba_bus_master.sv
// +----------------------------------------------------------------------+
// | tb_hba_bus_master : randomized self-checking bench for hba_bus_master|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_hba_bus_master;

  localparam int T  = 16;
  localparam int DW = 8;
  localparam int AW = 12;

  logic          hba_clk = 1'b0;
  logic          hba_reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rnw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          hba_select;
  logic          hba_rnw;
  logic [AW-1:0] hba_abus;
  logic [DW-1:0] hba_dbus;
  logic [DW-1:0] hba_dbus_slave = '0;
  logic          hba_xferack_slave = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 hba_clk = ~hba_clk;

  hba_bus_master #(
    .DBUS_WIDTH        (DW),
    .PERIPH_ADDR_WIDTH (4),
    .REG_ADDR_WIDTH    (8),
    .ADDR_WIDTH        (AW),
    .TIMEOUT_CYCLES    (T)
  ) dut (
    .hba_clk           (hba_clk),
    .hba_reset_n       (hba_reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_rnw           (req_rnw),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .hba_select        (hba_select),
    .hba_rnw           (hba_rnw),
    .hba_abus          (hba_abus),
    .hba_dbus          (hba_dbus),
    .hba_dbus_slave    (hba_dbus_slave),
    .hba_xferack_slave (hba_xferack_slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One request through to response consumption. ack_at is the 1-based select
  // cycle in which the slave acks (0 = never); hold is the number of cycles
  // the consumer stalls before taking the response.
  task automatic run_xfer(input logic rnw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] sd, input int ack_at, input int hold);
    int          sel_cnt;
    int          exp_sel;
    logic        exp_err;
    logic [DW-1:0] exp_rd;

    if (ack_at >= 1 && ack_at <= T) begin
      exp_sel = ack_at;
      exp_err = 1'b0;
      exp_rd  = rnw ? sd : '0;
    end else begin
      exp_sel = T;
      exp_err = 1'b1;
      exp_rd  = '0;
    end

    check_val("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_rnw   = rnw;
    req_addr  = addr;
    req_wdata = wd;
    @(negedge hba_clk);
    req_valid = 1'b0;
    req_rnw   = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);

    sel_cnt = 0;
    while (hba_select === 1'b1 && sel_cnt < T + 4) begin
      sel_cnt++;
      check_val("xfer_abus", hba_abus, addr);
      check_val("xfer_dbus", hba_dbus, wd);
      check_val("xfer_rnw", hba_rnw, rnw);
      check_val("xfer_req_ready", req_ready, 0);
      hba_xferack_slave = (sel_cnt == ack_at);
      hba_dbus_slave    = (sel_cnt == ack_at) ? sd : DW'($urandom);
      @(negedge hba_clk);
    end
    hba_xferack_slave = 1'b0;
    hba_dbus_slave    = '0;

    check_val("select_cycles", sel_cnt, exp_sel);
    check_val("rsp_valid", rsp_valid, 1);
    check_val("rsp_err", rsp_err, exp_err);
    check_val("rsp_rdata", rsp_rdata, exp_rd);
    check_val("resp_bus_idle", {hba_select, hba_rnw, hba_abus, hba_dbus}, 0);

    // Stall the consumer while a second request and stray acks are presented.
    for (int i = 0; i < hold; i++) begin
      req_valid         = 1'b1;
      hba_xferack_slave = 1'b1;
      hba_dbus_slave    = DW'($urandom);
      @(negedge hba_clk);
      check_val("hold_rsp_valid", rsp_valid, 1);
      check_val("hold_rsp_err", rsp_err, exp_err);
      check_val("hold_rsp_rdata", rsp_rdata, exp_rd);
      check_val("hold_req_ready", req_ready, 0);
      check_val("hold_select", hba_select, 0);
    end
    req_valid         = 1'b0;
    hba_xferack_slave = 1'b0;
    hba_dbus_slave    = '0;
    rsp_ready         = 1'b1;
    @(negedge hba_clk);
    rsp_ready = 1'b0;
    check_val("post_rsp_valid", rsp_valid, 0);
    check_val("post_req_ready", req_ready, 1);
    check_val("post_select", hba_select, 0);
  endtask

  initial begin
    int acc_cyc[3];
    int nacc;
    int ndone;
    int scyc;

    hba_reset_n = 1'b0;
    repeat (3) @(negedge hba_clk);
    check_val("reset_outputs", {hba_select, hba_rnw, hba_abus, hba_dbus, rsp_valid, rsp_rdata, rsp_err}, 0);
    check_val("reset_req_ready", req_ready, 1);
    hba_reset_n = 1'b1;
    @(negedge hba_clk);

    run_xfer(1'b0, 12'h203, 8'h5A, 8'h99, 2, 0);
    run_xfer(1'b1, 12'h101, 8'h00, 8'hC3, 4, 0);
    run_xfer(1'b1, 12'h0AA, 8'h00, 8'h55, 0, 4);
    run_xfer(1'b1, 12'h0E7, 8'h00, 8'h7E, 3, 10);
    run_xfer(1'b1, 12'h3C4, 8'h00, 8'hA5, T, 1);
    run_xfer(1'b0, 12'h001, 8'hF0, 8'h0F, 1, 0);

    // Back-to-back writes with rsp_ready high and a one-cycle-latency slave.
    rsp_ready = 1'b1;
    req_rnw   = 1'b0;
    nacc  = 0;
    ndone = 0;
    scyc  = 0;
    for (int c = 0; c < 60 && ndone < 3; c++) begin
      req_valid         = (nacc < 3);
      req_addr          = AW'(12'h300 + nacc);
      req_wdata         = DW'(8'h10 + nacc);
      hba_xferack_slave = 1'b0;
      if (hba_select) begin
        scyc++;
        check_val("b2b_abus", hba_abus, 12'h300 + nacc - 1);
        if (scyc == 2) hba_xferack_slave = 1'b1;
      end else begin
        scyc = 0;
      end
      if (rsp_valid) begin
        ndone++;
        check_val("b2b_rsp_err", rsp_err, 0);
      end
      if (req_ready && req_valid) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      @(negedge hba_clk);
    end
    req_valid         = 1'b0;
    rsp_ready         = 1'b0;
    hba_xferack_slave = 1'b0;
    check_val("b2b_accepts", nacc, 3);
    check_val("b2b_done", ndone, 3);
    check_val("b2b_gap1", acc_cyc[1] - acc_cyc[0], 4);
    check_val("b2b_gap2", acc_cyc[2] - acc_cyc[1], 4);
    @(negedge hba_clk);

    // Asynchronous reset in the middle of a transfer.
    req_valid = 1'b1;
    req_rnw   = 1'b1;
    req_addr  = 12'h456;
    @(negedge hba_clk);
    req_valid = 1'b0;
    check_val("pre_reset_select", hba_select, 1);
    @(negedge hba_clk);
    #2 hba_reset_n = 1'b0;
    #1;
    check_val("async_reset_select", hba_select, 0);
    check_val("async_reset_bus", {hba_rnw, hba_abus}, 0);
    check_val("async_reset_rsp_valid", rsp_valid, 0);
    @(negedge hba_clk);
    hba_reset_n = 1'b1;
    @(negedge hba_clk);
    run_xfer(1'b1, 12'h456, 8'h00, 8'h3D, 2, 0);

    // Randomized transactions; ack_at beyond T means no slave answers.
    for (int n = 0; n < 30; n++) begin
      run_xfer(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
               int'($urandom_range(0, T + 3)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hba_bus_master

`default_nettype wire
